// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared Q16.16 constants, FSM encoding and clog2 helper
package conv_pkg;

  // Q16.16 fixed-point format
  localparam int          FRAC_W    = 16;
  localparam logic [31:0] Q_ONE     = 32'h0001_0000;

  // Saturation bounds of a 32-bit Q16.16 result
  localparam logic [31:0] Q_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } conv_state_e;

  // Ceiling log2; clog2(1) = 0 so a single channel needs no tree stage
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// rtl/conv_adder_tree.sv - registered pairwise adder tree with valid and sideband delay lines
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int N_IN = 6,
  parameter int IN_W = 36,
  parameter int SB_W = 32
) (
  input  logic                 clk_global,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic [SB_W-1:0]      in_sb,
  output logic                 out_valid,
  output logic [IN_W-1:0]      out_sum,
  output logic [SB_W-1:0]      out_sb
);

  localparam int LVL    = clog2(N_IN);
  localparam int LEAVES = 1 << LVL;
  localparam int NODES  = LEAVES - 1;

  // Leaves padded to a power of two; the padding contributes nothing to the sum
  logic [LEAVES-1:0][IN_W-1:0] leaf;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N_IN) begin : g_used
      assign leaf[i] = in_data[i*IN_W +: IN_W];
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  if (LVL == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_sum   = leaf[0];
    assign out_sb    = in_sb;
  end else begin : g_tree
    // Nodes stored heap-style: node n has children 2n+1 and 2n+2, root is node 0.
    // Children numbered past the last internal node are leaves.
    logic [NODES-1:0][IN_W-1:0] sum_d, sum_q;
    logic [LVL-1:0]             vld_d, vld_q;
    logic [LVL-1:0][SB_W-1:0]   sb_d, sb_q;

    for (genvar n = 0; n < NODES; n++) begin : g_node
      if (2 * n + 2 < NODES) begin : g_inner
        assign sum_d[n] = sum_q[2*n+1] + sum_q[2*n+2];
      end else begin : g_bottom
        assign sum_d[n] = leaf[2*n+1-NODES] + leaf[2*n+2-NODES];
      end
    end

    // Valid and sideband shift one stage per level; flush kills every in-flight valid
    always_comb begin
      vld_d    = '0;
      sb_d     = '0;
      vld_d[0] = in_valid && !flush;
      sb_d[0]  = in_sb;
      for (int i = 1; i < LVL; i++) begin
        vld_d[i] = vld_q[i-1] && !flush;
        sb_d[i]  = sb_q[i-1];
      end
    end

    // Tree node, valid and sideband registers
    always_ff @(posedge clk_global or negedge reset) begin
      if (!reset) begin
        sum_q <= '0;
        vld_q <= '0;
        sb_q  <= '0;
      end else begin
        sum_q <= sum_d;
        vld_q <= vld_d;
        sb_q  <= sb_d;
      end
    end

    assign out_valid = vld_q[LVL-1];
    assign out_sum   = sum_q[0];
    assign out_sb    = sb_q[LVL-1];
  end

endmodule

// File: rtl/conv_channel_accum.sv
// rtl/conv_channel_accum.sv - cross-channel sum, bias, ReLU/saturation and feature-map sequencing
module conv_channel_accum
  import conv_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int N_CH     = 6,
  parameter int OUT_ROWS = 8,
  parameter int OUT_COLS = 8,
  parameter int RELU_EN  = 1
) (
  input  logic                   clk_global,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic [N_CH-1:0]        ch_valid,
  input  logic [DATA_W-1:0]      bias,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   finish,
  output logic                   invalid,
  output logic                   busy
);

  localparam int LVL   = clog2(N_CH);
  localparam int ACC_W = DATA_W + LVL;
  localparam int EXT_W = ACC_W + 1;
  localparam int TOTAL = OUT_ROWS * OUT_COLS;
  localparam int CNT_W = clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0]  TOTAL_C     = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [EXT_W-1:0]  SAT_MAX_EXT = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [EXT_W-1:0]  SAT_MIN_EXT = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SAT_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN     = {1'b1, {(DATA_W-1){1'b0}}};

  conv_state_e state_d, state_q;
  logic [CNT_W-1:0]  in_cnt_d, in_cnt_q;
  logic [CNT_W-1:0]  out_cnt_d, out_cnt_q;
  logic              invalid_d, invalid_q;
  logic              out_valid_d, out_valid_q;
  logic              finish_d, finish_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;

  logic                   full_beat;
  logic                   no_beat;
  logic                   accept;
  logic [N_CH*EXT_W-1:0]  ext_data;
  logic                   tree_valid;
  logic [EXT_W-1:0]       tree_sum;
  logic [DATA_W-1:0]      tree_bias;
  logic [EXT_W-1:0]       bias_ext;
  logic [EXT_W-1:0]       total;
  logic [DATA_W-1:0]      result;

  assign full_beat = &ch_valid;
  assign no_beat   = ~|ch_valid;
  // start always wins over a beat presented in the same cycle
  assign accept    = (state_q == RUN) && !start && full_beat;

  // Sign-extend every partial into the guard width so the tree never overflows
  for (genvar k = 0; k < N_CH; k++) begin : g_ext
    assign ext_data[k*EXT_W +: EXT_W] =
      {{(EXT_W-DATA_W){ch_data[k*DATA_W+DATA_W-1]}}, ch_data[k*DATA_W +: DATA_W]};
  end

  conv_adder_tree #(
    .N_IN (N_CH),
    .IN_W (EXT_W),
    .SB_W (DATA_W)
  ) u_tree (
    .clk_global (clk_global),
    .reset      (reset),
    .flush      (start),
    .in_valid   (accept),
    .in_data    (ext_data),
    .in_sb      (bias),
    .out_valid  (tree_valid),
    .out_sum    (tree_sum),
    .out_sb     (tree_bias)
  );

  assign bias_ext = {{(EXT_W-DATA_W){tree_bias[DATA_W-1]}}, tree_bias};

  // Map sequencing: beat and result counters, error flag, finish generation
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    invalid_d   = invalid_q;
    out_valid_d = tree_valid;
    finish_d    = 1'b0;
    if (start) begin
      // Arm or restart: anything still in flight belongs to an abandoned map
      state_d     = RUN;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      invalid_d   = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (full_beat) begin
            in_cnt_d = in_cnt_q + CNT_ONE;
            if (in_cnt_q == TOTAL_C - CNT_ONE) state_d = DRAIN;
          end else if (!no_beat) begin
            invalid_d = 1'b1;
          end
        end
        DRAIN: begin
          // finish is on the output this cycle; busy drops with the return to IDLE
          if (finish_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
      // Results emerge during RUN as well as DRAIN, so both phases count them
      if (tree_valid && (state_q != IDLE) && (out_cnt_q != TOTAL_C)) begin
        out_cnt_d = out_cnt_q + CNT_ONE;
        if ((state_q == DRAIN) && (out_cnt_q == TOTAL_C - CNT_ONE)) finish_d = 1'b1;
      end
    end
  end

  // Bias add, optional ReLU, then clamp to the output range
  always_comb begin
    total = tree_sum + bias_ext;
    if ((RELU_EN != 0) && total[EXT_W-1]) begin
      result = '0;
    end else if ($signed(total) > $signed(SAT_MAX_EXT)) begin
      result = SAT_MAX;
    end else if ($signed(total) < $signed(SAT_MIN_EXT)) begin
      result = SAT_MIN;
    end else begin
      result = total[DATA_W-1:0];
    end
    out_data_d = out_valid_d ? result : out_data_q;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_global or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      invalid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      invalid_q   <= invalid_d;
      out_valid_q <= out_valid_d;
      finish_q    <= finish_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign finish    = finish_q;
  assign invalid   = invalid_q;
  assign busy      = (state_q != IDLE);

endmodule
